prbs_checker: RTL

- Receive-side checker for the LFSR pattern stream recovered by clk_gen.
- Samples data_i on a one-cycle strobe, derived from the recovered clock, and self-synchronises a local LFSR to the incoming bits.
- Once locked, compares every sampled bit against the prediction and reports lock status, per-bit error pulses and saturating bit/error counters.
- Serves as the bit-error-rate monitor at the far end of the CDR path.

---
 rtl/prbs_checker.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises a local LFSR to data_i, then reports lock,
// per-bit errors and saturating bit/error counters. Define PRBS_CHECKER_INV_EN to accept an inverted stream.
module prbs_checker #(
    parameter int             N        = 8,
    parameter logic [N-1:0]   TAPS     = 8'hB8,
    parameter int             LOCK_CNT = 16,
    parameter int             WIN      = 64,
    parameter int             ERR_TH   = 8,
    parameter int             CW       = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clk_en_i,
    input  logic          data_i,
    input  logic          clr_i,
    output logic          lock_o,
    output logic          err_o,
    output logic [CW-1:0] bit_cnt_o,
    output logic [CW-1:0] err_cnt_o
);

    localparam int FW = $clog2(N + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(ERR_TH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic parity_f(input logic [N-1:0] v);
        return ^v;
    endfunction

    function automatic logic [CW-1:0] sat_inc_f(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    state_t          state_r, state_s;
    logic [N-1:0]    sreg_r, sreg_s, shift_s;
    logic [FW-1:0]   fill_r, fill_s;
    logic [MW-1:0]   match_r, match_s;
    logic [WW-1:0]   win_r, win_s;
    logic [EW-1:0]   werr_r, werr_s, werr_nxt_s;
    logic            lock_r, lock_s;
    logic            err_r, err_s;
    logic [CW-1:0]   bit_cnt_r, bit_cnt_s;
    logic [CW-1:0]   err_cnt_r, err_cnt_s;
    logic            pred_s, ref_s, mism_s, in_bit_s, inv_flag_s;
`ifdef PRBS_CHECKER_INV_EN
    logic [MW-1:0]   minv_r, minv_s;
    logic            inv_r, inv_s;
`endif

    // Next-state, shift register, window and counter logic; everything except clr_i waits for a strobe.
    always_comb begin
        state_s   = state_r;
        sreg_s    = sreg_r;
        fill_s    = fill_r;
        match_s   = match_r;
        win_s     = win_r;
        werr_s    = werr_r;
        lock_s    = lock_r;
        err_s     = 1'b0;
        bit_cnt_s = bit_cnt_r;
        err_cnt_s = err_cnt_r;
`ifdef PRBS_CHECKER_INV_EN
        minv_s     = minv_r;
        inv_s      = inv_r;
        inv_flag_s = inv_r;
`else
        inv_flag_s = 1'b0;
`endif
        pred_s     = parity_f(sreg_r & TAPS);
        ref_s      = pred_s ^ inv_flag_s;
        mism_s     = data_i ^ ref_s;
        // Once locked the register free-runs on its own prediction so one channel error costs one error.
        in_bit_s   = (state_r == LOCKED) ? ref_s : data_i;
        shift_s    = {sreg_r[N-2:0], in_bit_s};
        werr_nxt_s = werr_r + {{(EW-1){1'b0}}, mism_s};

        if (clk_en_i) begin
            sreg_s = shift_s;
            case (state_r)
                HUNT: begin
                    if (fill_r == FW'(N - 1)) begin
                        fill_s = '0;
                        if (shift_s != '0) begin
                            state_s = VERIFY;
                            match_s = '0;
                        end else begin
                            state_s = HUNT;
                        end
                    end else begin
                        fill_s = fill_r + FW'(1);
                    end
                end
                VERIFY: begin
                    if (shift_s == '0) begin
                        state_s = HUNT;
                        fill_s  = '0;
                        match_s = '0;
`ifdef PRBS_CHECKER_INV_EN
                        minv_s  = '0;
`endif
                    end else begin
                        if (data_i == pred_s) begin
                            if (match_r == MW'(LOCK_CNT - 1)) begin
                                state_s = LOCKED;
                                lock_s  = 1'b1;
                                match_s = '0;
                                win_s   = '0;
                                werr_s  = '0;
                            end else begin
                                match_s = match_r + MW'(1);
                            end
                        end else begin
                            match_s = '0;
                        end
`ifdef PRBS_CHECKER_INV_EN
                        if (data_i != pred_s) begin
                            if (minv_r == MW'(LOCK_CNT - 1)) begin
                                state_s = LOCKED;
                                lock_s  = 1'b1;
                                inv_s   = 1'b1;
                                minv_s  = '0;
                                win_s   = '0;
                                werr_s  = '0;
                            end else begin
                                minv_s = minv_r + MW'(1);
                            end
                        end else begin
                            minv_s = '0;
                        end
`endif
                    end
                end
                LOCKED: begin
                    err_s = mism_s;
                    if (werr_nxt_s == EW'(ERR_TH)) begin
                        state_s = HUNT;
                        lock_s  = 1'b0;
                        fill_s  = '0;
                        win_s   = '0;
                        werr_s  = '0;
`ifdef PRBS_CHECKER_INV_EN
                        inv_s   = 1'b0;
`endif
                    end else if (win_r == WW'(WIN - 1)) begin
                        win_s  = '0;
                        werr_s = '0;
                    end else begin
                        win_s  = win_r + WW'(1);
                        werr_s = werr_nxt_s;
                    end
                end
                default: begin
                    state_s = HUNT;
                    sreg_s  = '0;
                    fill_s  = '0;
                    match_s = '0;
                    win_s   = '0;
                    werr_s  = '0;
                    lock_s  = 1'b0;
                end
            endcase
        end else begin
            sreg_s = sreg_r;
        end

        // Clear wins over any increment on the same cycle.
        if (clr_i) begin
            bit_cnt_s = '0;
            err_cnt_s = '0;
        end else if (clk_en_i && (state_r == LOCKED)) begin
            bit_cnt_s = sat_inc_f(bit_cnt_r);
            err_cnt_s = mism_s ? sat_inc_f(err_cnt_r) : err_cnt_r;
        end else begin
            bit_cnt_s = bit_cnt_r;
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= HUNT;
            sreg_r    <= '0;
            fill_r    <= '0;
            match_r   <= '0;
            win_r     <= '0;
            werr_r    <= '0;
            lock_r    <= 1'b0;
            err_r     <= 1'b0;
            bit_cnt_r <= '0;
            err_cnt_r <= '0;
`ifdef PRBS_CHECKER_INV_EN
            minv_r    <= '0;
            inv_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            sreg_r    <= sreg_s;
            fill_r    <= fill_s;
            match_r   <= match_s;
            win_r     <= win_s;
            werr_r    <= werr_s;
            lock_r    <= lock_s;
            err_r     <= err_s;
            bit_cnt_r <= bit_cnt_s;
            err_cnt_r <= err_cnt_s;
`ifdef PRBS_CHECKER_INV_EN
            minv_r    <= minv_s;
            inv_r     <= inv_s;
`endif
        end
    end

    assign lock_o    = lock_r;
    assign err_o     = err_r;
    assign bit_cnt_o = bit_cnt_r;
    assign err_cnt_o = err_cnt_r;

endmodule
